// File: rtl/mrd_rdx5_seq.sv
// Sequencer for the mrd_dft_rdx5 radix-5 core: gathers 5-sample groups, issues them under
// output-buffer credit control, captures results and re-serialises. Stats: MRD_RDX5_STAT_EN.
module mrd_rdx5_seq #(
    parameter int W        = 30,
    parameter int OBUF_GRP = 2,
    parameter int CORE_LAT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_real,
    input  logic [W-1:0]   s_imag,
    output logic           core_in_val,
    output logic [5*W-1:0] core_din_real,
    output logic [5*W-1:0] core_din_imag,
    input  logic           core_out_val,
    input  logic [5*W-1:0] core_dout_real,
    input  logic [5*W-1:0] core_dout_imag,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_real,
    output logic [W-1:0]   m_imag,
    output logic           m_last,
`ifdef MRD_RDX5_STAT_EN
    output logic [15:0]    grp_cnt,
    output logic [15:0]    stall_cnt,
`endif
    output logic           err
);
    localparam int PW = (OBUF_GRP > 1) ? $clog2(OBUF_GRP) : 1;
    localparam int CW = $clog2(OBUF_GRP + 1);
    localparam int IW = $clog2(CORE_LAT + 2);

    logic [2:0]     gcnt_q, gcnt_d;
    logic           gfull_q, gfull_d;
    logic [W-1:0]   g_re_q [5];
    logic [W-1:0]   g_re_d [5];
    logic [W-1:0]   g_im_q [5];
    logic [W-1:0]   g_im_d [5];
    logic [CW-1:0]  used_q, used_d;
    logic [IW-1:0]  infl_q, infl_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  fcnt_q, fcnt_d;
    logic [2:0]     olane_q, olane_d;
    logic           err_q, err_d;
    logic [5*W-1:0] f_re_q [OBUF_GRP];
    logic [5*W-1:0] f_re_d [OBUF_GRP];
    logic [5*W-1:0] f_im_q [OBUF_GRP];
    logic [5*W-1:0] f_im_d [OBUF_GRP];

    logic           issue;
    logic           s_acc;
    logic           m_hs;
    logic           pop;
    logic           fifo_full;
    logic           cap_bad;
    logic           wr;
    logic           infl_dec;
    logic [5*W-1:0] head_re;
    logic [5*W-1:0] head_im;

    // Credits cover both buffered and in-flight groups, so a capture always finds room.
    always_comb begin
        issue     = gfull_q & (used_q < CW'(OBUF_GRP));
        s_ready   = rst_n & (~gfull_q | issue);
        s_acc     = s_valid & s_ready;
        m_valid   = (fcnt_q != '0);
        m_hs      = m_valid & m_ready;
        pop       = m_hs & (olane_q == 3'd4);
        fifo_full = (fcnt_q == CW'(OBUF_GRP));
        cap_bad   = core_out_val & ((infl_q == '0) | fifo_full);
        wr        = core_out_val & ~cap_bad;
        infl_dec  = core_out_val & (infl_q != '0);
    end

    always_comb begin
        core_in_val   = issue;
        core_din_real = '0;
        core_din_imag = '0;
        for (int k = 0; k < 5; k++) begin
            core_din_real[k*W +: W] = g_re_q[k];
            core_din_imag[k*W +: W] = g_im_q[k];
        end
    end

    always_comb begin
        head_re = f_re_q[rptr_q];
        head_im = f_im_q[rptr_q];
        m_real  = head_re[olane_q*W +: W];
        m_imag  = head_im[olane_q*W +: W];
        m_last  = (olane_q == 3'd4);
        err     = err_q;
    end

    always_comb begin
        gcnt_d  = gcnt_q;
        gfull_d = gfull_q;
        g_re_d  = g_re_q;
        g_im_d  = g_im_q;
        if (issue) begin
            gfull_d = 1'b0;
        end
        // A sample taken in the issue cycle lands in lane 0 of the next group.
        if (s_acc) begin
            g_re_d[gcnt_q] = s_real;
            g_im_d[gcnt_q] = s_imag;
            if (gcnt_q == 3'd4) begin
                gcnt_d  = 3'd0;
                gfull_d = 1'b1;
            end else begin
                gcnt_d = gcnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        used_d = used_q;
        if (issue && !pop) begin
            used_d = used_q + CW'(1);
        end else if (!issue && pop) begin
            used_d = used_q - CW'(1);
        end

        infl_d = infl_q;
        if (issue && !infl_dec) begin
            infl_d = infl_q + IW'(1);
        end else if (!issue && infl_dec) begin
            infl_d = infl_q - IW'(1);
        end

        wptr_d = wptr_q;
        if (wr) begin
            wptr_d = (wptr_q == PW'(OBUF_GRP - 1)) ? '0 : wptr_q + PW'(1);
        end

        rptr_d = rptr_q;
        if (pop) begin
            rptr_d = (rptr_q == PW'(OBUF_GRP - 1)) ? '0 : rptr_q + PW'(1);
        end

        fcnt_d = fcnt_q;
        if (wr && !pop) begin
            fcnt_d = fcnt_q + CW'(1);
        end else if (!wr && pop) begin
            fcnt_d = fcnt_q - CW'(1);
        end

        olane_d = olane_q;
        if (m_hs) begin
            olane_d = (olane_q == 3'd4) ? 3'd0 : olane_q + 3'd1;
        end

        err_d = err_q | cap_bad;

        f_re_d = f_re_q;
        f_im_d = f_im_q;
        if (wr) begin
            f_re_d[wptr_q] = core_dout_real;
            f_im_d[wptr_q] = core_dout_imag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gcnt_q  <= '0;
            gfull_q <= 1'b0;
            used_q  <= '0;
            infl_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
            olane_q <= '0;
            err_q   <= 1'b0;
        end else begin
            gcnt_q  <= gcnt_d;
            gfull_q <= gfull_d;
            used_q  <= used_d;
            infl_q  <= infl_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
            olane_q <= olane_d;
            err_q   <= err_d;
        end
    end

    // Sample storage carries no reset; occupancy state alone decides validity.
    always_ff @(posedge clk) begin
        g_re_q <= g_re_d;
        g_im_q <= g_im_d;
        f_re_q <= f_re_d;
        f_im_q <= f_im_d;
    end

`ifdef MRD_RDX5_STAT_EN
    logic [15:0] grp_cnt_q, grp_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        grp_cnt_d   = issue ? grp_cnt_q + 16'd1 : grp_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (gfull_q && !issue && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        grp_cnt   = grp_cnt_q;
        stall_cnt = stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grp_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            grp_cnt_q   <= grp_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
